// File: rtl/mux_gate_pkg.sv
// Shared definitions for the mux-gate arbiter: op codes, FSM state encoding
// and a small op-decoding helper.
package mux_gate_pkg;

    // Op codes carried on req_op; each maps to an (i0, i1) pair per slice.
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_NOT  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    // Result register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // True for the one op code that has no gate function.
    function automatic logic isIllegal(input logic [2:0] op);
        return op == OP_ILL;
    endfunction

endpackage

// File: rtl/Mux2x1.sv
// Single-bit 2:1 multiplexer; one slice of the shared gate datapath.
module Mux2x1 (
    input  logic i0,
    input  logic i1,
    input  logic s,
    output logic y
);

    assign y = s ? i1 : i0;

endmodule

// File: rtl/mux_gate_cfg.sv
// Translates an op code and operand B into the per-bit i0/i1 inputs of the
// Mux2x1 slices. Operand A drives the slice selects, so every op becomes
// "pick i1 where a=1, i0 where a=0".
module mux_gate_cfg
    import mux_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] i0,
    output logic [WIDTH-1:0] i1
);

    // Select the slice data inputs for the requested op.
    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        i0 = '0;
        i1 = '0;
        unique case (op)
            OP_AND:  begin i0 = '0;  i1 = b;  end
            OP_OR:   begin i0 = b;   i1 = '1; end
            OP_NAND: begin i0 = '1;  i1 = ~b; end
            OP_NOR:  begin i0 = ~b;  i1 = '0; end
            OP_NOT:  begin i0 = '1;  i1 = '0; end
            OP_XOR:  begin i0 = b;   i1 = ~b; end
            OP_XNOR: begin i0 = ~b;  i1 = b;  end
            OP_ILL:  begin i0 = '0;  i1 = '0; end
            default: begin i0 = '0;  i1 = '0; end
        endcase
    end

endmodule

// File: rtl/mux_gate_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit Mux2x1 gate unit among NREQ
// requesters, with a one-deep registered result on a valid/ready port.
// Optional feature: define MUX_GATE_ERR_EN to add the resp_err output,
// which flags results produced from the illegal op code.
module mux_gate_arbiter
    import mux_gate_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_data
`ifdef MUX_GATE_ERR_EN
    ,
    output logic                  resp_err
`endif
);

    state_t           state;
    state_t           nextState;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   winner;
    logic             found;
    logic             anyValid;
    logic             grantAllowed;
    logic             doGrant;
    logic [2:0]       selOp;
    logic [WIDTH-1:0] selA;
    logic [WIDTH-1:0] selB;
    logic [WIDTH-1:0] sliceI0;
    logic [WIDTH-1:0] sliceI1;
    logic [WIDTH-1:0] muxOut;

    assign anyValid = |req_valid;

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[(int'(ptr) + i) % NREQ]) begin
                found  = 1'b1;
                winner = IDW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    // A grant may only happen when the result slot is free or being drained this cycle.
    always_comb begin
        grantAllowed = rst_n && ((state == ST_EMPTY) || resp_ready);
        doGrant      = grantAllowed && found;
        req_ready    = doGrant ? (NREQ'(1) << winner) : '0;
    end

    // Route the winner's operands to the shared gate unit.
    always_comb begin
        selOp = req_op[3*int'(winner) +: 3];
        selA  = req_a[WIDTH*int'(winner) +: WIDTH];
        selB  = req_b[WIDTH*int'(winner) +: WIDTH];
    end

    mux_gate_cfg #(
        .WIDTH (WIDTH)
    ) u_cfg (
        .op (selOp),
        .b  (selB),
        .i0 (sliceI0),
        .i1 (sliceI1)
    );

    for (genvar k = 0; k < WIDTH; k++) begin : g_slice
        Mux2x1 u_mux (
            .i0 (sliceI0[k]),
            .i1 (sliceI1[k]),
            .s  (selA[k]),
            .y  (muxOut[k])
        );
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) state <= ST_EMPTY;
        else        state <= nextState;
    end

    // FSM next state: fill on any request, drain when consumed with nothing new.
    always_comb begin
        nextState = state;
        unique case (state)
            ST_EMPTY: if (anyValid) nextState = ST_FULL;
            ST_FULL:  if (resp_ready && !anyValid) nextState = ST_EMPTY;
            default:  nextState = ST_EMPTY;
        endcase
    end

    // FSM outputs: the result port is valid exactly while the slot is full.
    always_comb begin
        resp_valid = (state == ST_FULL);
    end

    // Round-robin pointer advances past the winner on each grant only.
    always_ff @(posedge clk) begin
        if (!rst_n)       ptr <= '0;
        else if (doGrant) ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end

    // Result register: load on grant, otherwise hold for the consumer.
    always_ff @(posedge clk) begin
        // NOTE: the result register is reset because its contents are observable outputs.
        if (!rst_n) begin
            resp_id   <= '0;
            resp_data <= '0;
        end else if (doGrant) begin
            resp_id   <= winner;
            resp_data <= muxOut;
        end
    end

`ifdef MUX_GATE_ERR_EN
    // Error flag travels with the result it describes.
    always_ff @(posedge clk) begin
        if (!rst_n)       resp_err <= 1'b0;
        else if (doGrant) resp_err <= isIllegal(selOp);
    end
`endif

endmodule
